// File: rtl/dio_pkg.sv
// Shared types and constants for the data_io memory-side scheduler.
package dio_pkg;

    localparam int AW_DEFAULT = 23;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] REQ_UIO = 2'd0;
    localparam logic [1:0] REQ_WR  = 2'd1;
    localparam logic [1:0] REQ_RD  = 2'd2;

endpackage

// File: rtl/toggle_edge.sv
// Toggle-to-pulse converter. The history register follows the input every cycle,
// including during reset, so a strobe level held through reset never fires.
module toggle_edge (
    input  logic clk,
    input  logic strobe_i,
    output logic pulse_o
);

    logic hist_q;

    // History of the toggle input; loading it unconditionally also covers reset.
    always_ff @(posedge clk) begin
        hist_q <= strobe_i;
    end

    assign pulse_o = strobe_i ^ hist_q;

endmodule

// File: rtl/dio_mem_sched.sv
// Memory-side scheduler: turns upload/DMA toggle strobes into single req/ack
// RAM transactions and owns the DMA address counter and read-data register.
module dio_mem_sched
    import dio_pkg::*;
#(
    parameter int            AW             = AW_DEFAULT,
    parameter logic [AW-1:0] RESET_DMA_ADDR = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          uio_strobe,
    input  logic [15:0]   uio_data,
    input  logic [AW-1:0] uio_addr,
    input  logic          mist_wr_strobe,
    input  logic [15:0]   mist_wdata,
    input  logic          mist_rd_strobe,
    input  logic          dma_addr_load,
    input  logic [AW-1:0] dma_addr_in,
    input  logic          dma_rd_mode,
    output logic [15:0]   rd_data,
    output logic [AW-1:0] dma_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata,
    output logic          busy,
    output logic          overrun
);

    logic uio_ev_s, wr_ev_s, rd_ev_s;

    toggle_edge u_te_uio (.clk(clk), .strobe_i(uio_strobe),     .pulse_o(uio_ev_s));
    toggle_edge u_te_wr  (.clk(clk), .strobe_i(mist_wr_strobe), .pulse_o(wr_ev_s));
    toggle_edge u_te_rd  (.clk(clk), .strobe_i(mist_rd_strobe), .pulse_o(rd_ev_s));

    state_t        state_q, state_d;
    logic [1:0]    cur_q, cur_d;
    logic [2:0]    pend_q, pend_d;
    logic [15:0]   uio_data_q, uio_data_d;
    logic [AW-1:0] uio_addr_q, uio_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [AW-1:0] dma_addr_q, dma_addr_d;
    logic          overrun_q, overrun_d;
    logic          busy_q;

    logic          ack_s;
    logic [2:0]    ev_s, ack_clr_s, held_s, accept_s, ovr_s;

    // A slot being acked this cycle counts as free for a coinciding event.
    always_comb begin
        ev_s      = {rd_ev_s | (dma_addr_load & dma_rd_mode), wr_ev_s, uio_ev_s};
        ack_s     = (state_q == WAIT) & mem_ack;
        ack_clr_s = {ack_s & (cur_q == REQ_RD), ack_s & (cur_q == REQ_WR),
                     ack_s & (cur_q == REQ_UIO)};
        held_s    = pend_q & ~ack_clr_s;
        accept_s  = ev_s & ~held_s;
        ovr_s     = ev_s & held_s;
    end

    // Arbiter, transaction FSM, slot capture and DMA address next-state.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        pend_d      = held_s | ev_s;
        uio_data_d  = accept_s[0] ? uio_data : uio_data_q;
        uio_addr_d  = accept_s[0] ? uio_addr : uio_addr_q;
        wr_data_d   = accept_s[1] ? mist_wdata : wr_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        dma_addr_d  = dma_addr_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    mem_req_d = 1'b1;
                    state_d   = WAIT;
                    if (pend_q[0]) begin
                        cur_d       = REQ_UIO;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = uio_addr_q;
                        mem_wdata_d = uio_data_q;
                    end else if (pend_q[1]) begin
                        cur_d       = REQ_WR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = dma_addr_q;
                        mem_wdata_d = wr_data_q;
                    end else begin
                        cur_d      = REQ_RD;
                        mem_we_d   = 1'b0;
                        mem_addr_d = dma_addr_q;
                    end
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (cur_q == REQ_RD) begin
                        rd_data_d  = mem_rdata;
                        dma_addr_d = dma_addr_q + {{(AW-1){1'b0}}, 1'b1};
                    end else if (cur_q == REQ_WR) begin
                        dma_addr_d = dma_addr_q + {{(AW-1){1'b0}}, 1'b1};
                    end else begin
                        dma_addr_d = dma_addr_q;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        // A load overrides any increment from a coinciding ack.
        if (dma_addr_load) begin
            dma_addr_d = dma_addr_in;
        end else begin
            dma_addr_d = dma_addr_d;
        end
        overrun_d = (dma_addr_load ? 1'b0 : overrun_q) | (|ovr_s);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_q       <= REQ_UIO;
            pend_q      <= 3'b000;
            uio_data_q  <= 16'h0000;
            uio_addr_q  <= {AW{1'b0}};
            wr_data_q   <= 16'h0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= 16'h0000;
            rd_data_q   <= 16'h0000;
            dma_addr_q  <= RESET_DMA_ADDR;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            uio_data_q  <= uio_data_d;
            uio_addr_q  <= uio_addr_d;
            wr_data_q   <= wr_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            dma_addr_q  <= dma_addr_d;
            overrun_q   <= overrun_d;
            busy_q      <= (state_d != IDLE) | (|pend_d);
        end
    end

    assign rd_data   = rd_data_q;
    assign dma_addr  = dma_addr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dio_mem_sched.sv
// Self-checking bench for dio_mem_sched: table-driven transactions against a
// memory-model scoreboard, plus hand-written overrun, wrap and reset sequences.
module tb_dio_mem_sched;

    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          uio_strobe;
    logic [15:0]   uio_data;
    logic [AW-1:0] uio_addr;
    logic          mist_wr_strobe;
    logic [15:0]   mist_wdata;
    logic          mist_rd_strobe;
    logic          dma_addr_load;
    logic [AW-1:0] dma_addr_in;
    logic          dma_rd_mode;
    logic [15:0]   rd_data;
    logic [AW-1:0] dma_addr;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_ack;
    logic [15:0]   mem_rdata;
    logic          busy;
    logic          overrun;

    dio_mem_sched #(.AW(AW), .RESET_DMA_ADDR(23'h000000)) dut (
        .clk(clk), .reset_n(reset_n),
        .uio_strobe(uio_strobe), .uio_data(uio_data), .uio_addr(uio_addr),
        .mist_wr_strobe(mist_wr_strobe), .mist_wdata(mist_wdata),
        .mist_rd_strobe(mist_rd_strobe),
        .dma_addr_load(dma_addr_load), .dma_addr_in(dma_addr_in), .dma_rd_mode(dma_rd_mode),
        .rd_data(rd_data), .dma_addr(dma_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [15:0]   rdata;
    } txn_t;

    // kind: 0 load+prefetch, 1 upload, 2 DMA write, 3 read toggle, 4 load only
    typedef struct {
        int            kind;
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [15:0]   rdata;
        int            lat;
        logic [AW-1:0] e_dma;
        logic [15:0]   e_rd;
    } vec_t;

    txn_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur_lat = 3;
    int   cnt = 0;
    logic hold = 1'b0;
    logic force_ack = 1'b0;
    logic [15:0] force_rdata = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory model: acks after cur_lat cycles of mem_req and checks the scoreboard.
    initial begin
        txn_t t;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = force_rdata;
                force_ack = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !hold) begin
                cnt++;
                if (cnt >= cur_lat) begin
                    cnt = 0;
                    if (sbq.size() == 0) begin
                        chk("unexpected_txn", {8'h00, mem_we, mem_addr}, 32'hFFFFFFFF);
                        mem_rdata = 16'h0000;
                    end else begin
                        t = sbq.pop_front();
                        chk("txn_we", {31'd0, mem_we}, {31'd0, t.we});
                        chk("txn_addr", {9'd0, mem_addr}, {9'd0, t.addr});
                        if (t.we) chk("txn_wdata", {16'd0, mem_wdata}, {16'd0, t.wdata});
                        mem_rdata = t.rdata;
                    end
                    mem_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        tick();
        while ((busy || mem_req) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_req(input string nm);
        int k;
        k = 0;
        while (!mem_req && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk({nm, "_req_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic mode);
        dma_addr_load = 1'b1;
        dma_addr_in   = a;
        dma_rd_mode   = mode;
        tick();
        dma_addr_load = 1'b0;
        dma_rd_mode   = 1'b0;
    endtask

    task automatic push(input logic we, input logic [AW-1:0] a, input logic [15:0] wd,
                        input logic [15:0] rd);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd;
        sbq.push_back(t);
    endtask

    initial begin
        vec_t          vt[7];
        logic [AW-1:0] m_dma;
        int            nreq;

        vt[0] = '{0, 23'h000100, 16'h0000, 16'hBEEF, 3, 23'h000101, 16'hBEEF};
        vt[1] = '{3, 23'h000000, 16'h0000, 16'h1111, 1, 23'h000102, 16'h1111};
        vt[2] = '{2, 23'h000000, 16'h5678, 16'h0000, 2, 23'h000103, 16'h1111};
        vt[3] = '{1, 23'h700000, 16'h1234, 16'h0000, 1, 23'h000103, 16'h1111};
        vt[4] = '{0, 23'h7FFFFF, 16'h0000, 16'hA5A5, 2, 23'h000000, 16'hA5A5};
        vt[5] = '{2, 23'h000000, 16'h0F0F, 16'h0000, 3, 23'h000001, 16'hA5A5};
        vt[6] = '{4, 23'h000010, 16'h0000, 16'h0000, 1, 23'h000010, 16'hA5A5};

        reset_n = 1'b0; uio_strobe = 1'b1; uio_data = 16'h0000; uio_addr = 23'h000000;
        mist_wr_strobe = 1'b0; mist_wdata = 16'h0000; mist_rd_strobe = 1'b0;
        dma_addr_load = 1'b0; dma_addr_in = 23'h000000; dma_rd_mode = 1'b0;

        // Reset with uio_strobe held high: no event after release.
        repeat (3) tick();
        reset_n = 1'b1;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req) nreq++;
        end
        chk("rst_no_req", nreq, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_dma_addr", {9'd0, dma_addr}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // Table-driven single transactions.
        m_dma = 23'h000000;
        for (int i = 0; i < 7; i++) begin
            cur_lat = vt[i].lat;
            case (vt[i].kind)
                0: begin
                    push(1'b0, vt[i].a, 16'h0000, vt[i].rdata);
                    m_dma = vt[i].a + 23'd1;
                    do_load(vt[i].a, 1'b1);
                end
                1: begin
                    push(1'b1, vt[i].a, vt[i].d, 16'h0000);
                    uio_addr = vt[i].a; uio_data = vt[i].d; uio_strobe = ~uio_strobe;
                end
                2: begin
                    push(1'b1, m_dma, vt[i].d, 16'h0000);
                    m_dma = m_dma + 23'd1;
                    mist_wdata = vt[i].d; mist_wr_strobe = ~mist_wr_strobe;
                end
                3: begin
                    push(1'b0, m_dma, 16'h0000, vt[i].rdata);
                    m_dma = m_dma + 23'd1;
                    mist_rd_strobe = ~mist_rd_strobe;
                end
                default: begin
                    m_dma = vt[i].a;
                    do_load(vt[i].a, 1'b0);
                end
            endcase
            wait_idle("vec");
            chk($sformatf("vec%0d_dma", i), {9'd0, dma_addr}, {9'd0, vt[i].e_dma});
            chk($sformatf("vec%0d_rd", i), {16'd0, rd_data}, {16'd0, vt[i].e_rd});
            chk($sformatf("vec%0d_ovr", i), {31'd0, overrun}, 32'd0);
        end

        // Simultaneous upload and DMA write: upload goes first.
        cur_lat = 2;
        push(1'b1, 23'h700000, 16'h1234, 16'h0000);
        push(1'b1, 23'h000010, 16'h5678, 16'h0000);
        uio_addr = 23'h700000; uio_data = 16'h1234; uio_strobe = ~uio_strobe;
        mist_wdata = 16'h5678; mist_wr_strobe = ~mist_wr_strobe;
        wait_idle("simul");
        chk("simul_dma", {9'd0, dma_addr}, 32'h00000011);
        chk("simul_ovr", {31'd0, overrun}, 32'd0);

        // Second write while the first is still pending: dropped, overrun set.
        hold = 1'b1;
        push(1'b1, 23'h000011, 16'hAAAA, 16'h0000);
        mist_wdata = 16'hAAAA; mist_wr_strobe = ~mist_wr_strobe;
        tick(); tick();
        mist_wdata = 16'hBBBB; mist_wr_strobe = ~mist_wr_strobe;
        tick(); tick();
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        hold = 1'b0;
        wait_idle("ovr");
        chk("ovr_dma", {9'd0, dma_addr}, 32'h00000012);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        do_load(23'h000020, 1'b0);
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        chk("ovr_load_dma", {9'd0, dma_addr}, 32'h00000020);

        // Load coinciding with a read ack: load wins, rd_data still updates.
        hold = 1'b1;
        do_load(23'h000030, 1'b1);
        wait_req("ldack");
        chk("ldack_addr", {9'd0, mem_addr}, 32'h00000030);
        force_rdata = 16'h7777;
        force_ack = 1'b1;
        tick();
        dma_addr_load = 1'b1; dma_addr_in = 23'h000020; dma_rd_mode = 1'b0;
        tick();
        dma_addr_load = 1'b0;
        hold = 1'b0;
        wait_idle("ldack");
        chk("ldack_dma", {9'd0, dma_addr}, 32'h00000020);
        chk("ldack_rd", {16'd0, rd_data}, 32'h00007777);

        // Reset during WAIT, then a late ack that must be ignored.
        hold = 1'b1;
        do_load(23'h000040, 1'b1);
        wait_req("rstw");
        reset_n = 1'b0;
        tick();
        chk("rstw_req", {31'd0, mem_req}, 32'd0);
        reset_n = 1'b1;
        force_rdata = 16'h9999;
        force_ack = 1'b1;
        repeat (4) tick();
        hold = 1'b0;
        chk("rstw_req2", {31'd0, mem_req}, 32'd0);
        chk("rstw_rd", {16'd0, rd_data}, 32'd0);
        chk("rstw_dma", {9'd0, dma_addr}, 32'd0);
        chk("rstw_busy", {31'd0, busy}, 32'd0);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
